// File: rtl/align_result_collector.sv
// Captures an aligned R/Q pair when the accelerator signals done, streams the
// non-padding slots as beats from high to low index, and reports alignment statistics.
module align_result_collector #(
  parameter int unsigned L        = 8,
  parameter logic [2:0]  GAP      = 3'b111,
  parameter int          MATCH    = 2,
  parameter int          MISMATCH = 1,
  parameter int          GAPPEN   = 2,
  localparam int unsigned N  = L + 2,
  localparam int unsigned CW = $clog2(N + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                acc_ready,
  input  logic [3*L+5:0]      r_aligned_in,
  input  logic [3*L+5:0]      q_aligned_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2:0]          out_r,
  output logic [2:0]          out_q,
  output logic                out_last,
  output logic                res_valid,
  output logic signed [7:0]   score,
  output logic [CW-1:0]       match_cnt,
  output logic [CW-1:0]       mismatch_cnt,
  output logic [CW-1:0]       gap_cnt,
  output logic                busy,
  output logic                overrun
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic signed [15:0] MatchD = 16'(MATCH);
  localparam logic signed [15:0] MisD   = 16'(-MISMATCH);
  localparam logic signed [15:0] GapD   = 16'(-GAPPEN);

  typedef enum logic [1:0] {IDLE, EMIT, REPORT} state_t;

  state_t               state_q, state_d;
  logic                 accPrev_q;
  logic [N-1:0][2:0]    rBuf_q, qBuf_q;
  logic [N-1:0][2:0]    rIn, qIn;
  logic [N-1:0]         mask_q, captMask;
  logic [IW-1:0]        idx_q, idx_d;
  logic signed [7:0]    score_q, score_d, satScore;
  logic [CW-1:0]        match_q, match_d, mismatch_q, mismatch_d, gap_q, gap_d;
  logic                 overrun_q;
  logic                 accRise, capture, slotLive, isGap, isMatch;
  logic [2:0]           curR, curQ;
  logic [N-1:0]         belowMask;
  logic signed [15:0]   delta, sum;

  assign rIn = r_aligned_in;
  assign qIn = q_aligned_in;

  always_comb begin
    captMask = '0;
    for (int k = 0; k < int'(N); k++) begin
      captMask[k] = (rIn[k] != 3'b000) || (qIn[k] != 3'b000);
    end
  end

  assign accRise   = acc_ready && !accPrev_q;
  assign capture   = (state_q == IDLE) && accRise;
  assign curR      = rBuf_q[idx_q];
  assign curQ      = qBuf_q[idx_q];
  assign slotLive  = mask_q[idx_q];
  assign belowMask = mask_q & ((N'(1) << idx_q) - N'(1));

  // Slot classification and saturating score update for the slot under the index.
  always_comb begin
    isGap   = (curR == GAP) || (curQ == GAP);
    isMatch = !isGap && (curR == curQ);
    delta   = isGap ? GapD : (isMatch ? MatchD : MisD);
    sum     = $signed({{8{score_q[7]}}, score_q}) + delta;
    if (sum > 16'sd127) begin
      satScore = 8'sd127;
    end else if (sum < -16'sd128) begin
      satScore = -8'sd128;
    end else begin
      satScore = sum[7:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    score_d    = score_q;
    match_d    = match_q;
    mismatch_d = mismatch_q;
    gap_d      = gap_q;
    unique case (state_q)
      IDLE: begin
        if (accRise) begin
          state_d    = EMIT;
          idx_d      = IW'(N - 1);
          score_d    = '0;
          match_d    = '0;
          mismatch_d = '0;
          gap_d      = '0;
        end
      end
      EMIT: begin
        // Padding slots advance unconditionally; live slots wait for the handshake.
        if (!slotLive || out_ready) begin
          if (slotLive) begin
            score_d = satScore;
            if (isGap) begin
              gap_d = gap_q + CW'(1);
            end else if (isMatch) begin
              match_d = match_q + CW'(1);
            end else begin
              mismatch_d = mismatch_q + CW'(1);
            end
          end
          if (idx_q == '0) begin
            state_d = REPORT;
          end else begin
            idx_d = idx_q - IW'(1);
          end
        end
      end
      REPORT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      accPrev_q  <= 1'b0;
      rBuf_q     <= '0;
      qBuf_q     <= '0;
      mask_q     <= '0;
      idx_q      <= '0;
      score_q    <= '0;
      match_q    <= '0;
      mismatch_q <= '0;
      gap_q      <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      accPrev_q  <= acc_ready;
      idx_q      <= idx_d;
      score_q    <= score_d;
      match_q    <= match_d;
      mismatch_q <= mismatch_d;
      gap_q      <= gap_d;
      if (capture) begin
        rBuf_q <= rIn;
        qBuf_q <= qIn;
        mask_q <= captMask;
      end
      if (accRise && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign out_valid    = (state_q == EMIT) && slotLive;
  assign out_r        = out_valid ? curR : 3'b000;
  assign out_q        = out_valid ? curQ : 3'b000;
  assign out_last     = out_valid && (belowMask == '0);
  assign res_valid    = (state_q == REPORT);
  assign busy         = (state_q != IDLE);
  assign overrun      = overrun_q;
  assign score        = score_q;
  assign match_cnt    = match_q;
  assign mismatch_cnt = mismatch_q;
  assign gap_cnt      = gap_q;

endmodule

// File: tb/tb_align_result_collector.sv
// Randomized bench for align_result_collector: two instances (default gap penalty and a
// large one for saturation) share stimulus and are compared against a slot-list model.
module tb_align_result_collector;

  localparam int L  = 8;
  localparam int N  = L + 2;
  localparam int W  = 3 * N;
  localparam int CW = $clog2(N + 1);
  localparam logic [2:0] GAPC = 3'b111;
  localparam int PEN_A = 2;
  localparam int PEN_B = 20;

  logic clk = 1'b0;
  logic rst_n, acc_ready, out_ready;
  logic [W-1:0] rBus, qBus;

  logic aValid, aLast, aRes, aBusy, aOvr;
  logic [2:0] aR, aQ;
  logic signed [7:0] aScore;
  logic [CW-1:0] aMat, aMis, aGap;
  logic bValid, bLast, bRes, bBusy, bOvr;
  logic [2:0] bR, bQ;
  logic signed [7:0] bScore;
  logic [CW-1:0] bMat, bMis, bGap;

  int compared = 0;
  int mismatched = 0;

  logic [2:0] expR[$];
  logic [2:0] expQ[$];
  bit expL[$];
  int expMat, expMis, expGapN, expScoreA, expScoreB;
  bit expOvr = 1'b0;

  align_result_collector #(.L(L), .GAP(GAPC), .MATCH(2), .MISMATCH(1), .GAPPEN(PEN_A)) uA (
    .clk(clk), .rst_n(rst_n), .acc_ready(acc_ready),
    .r_aligned_in(rBus), .q_aligned_in(qBus),
    .out_valid(aValid), .out_ready(out_ready), .out_r(aR), .out_q(aQ), .out_last(aLast),
    .res_valid(aRes), .score(aScore), .match_cnt(aMat), .mismatch_cnt(aMis), .gap_cnt(aGap),
    .busy(aBusy), .overrun(aOvr)
  );

  align_result_collector #(.L(L), .GAP(GAPC), .MATCH(2), .MISMATCH(1), .GAPPEN(PEN_B)) uB (
    .clk(clk), .rst_n(rst_n), .acc_ready(acc_ready),
    .r_aligned_in(rBus), .q_aligned_in(qBus),
    .out_valid(bValid), .out_ready(out_ready), .out_r(bR), .out_q(bQ), .out_last(bLast),
    .res_valid(bRes), .score(bScore), .match_cnt(bMat), .mismatch_cnt(bMis), .gap_cnt(bGap),
    .busy(bBusy), .overrun(bOvr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int sat8(input int v);
    return (v > 127) ? 127 : ((v < -128) ? -128 : v);
  endfunction

  // Expected beat list and statistics straight from the slot rules.
  task automatic buildModel(input logic [W-1:0] rb, input logic [W-1:0] qb);
    logic [2:0] r, q;
    int lowest;
    lowest = -1;
    expR.delete(); expQ.delete(); expL.delete();
    expMat = 0; expMis = 0; expGapN = 0; expScoreA = 0; expScoreB = 0;
    for (int k = 0; k < N; k++) begin
      if (rb[3*k +: 3] != 3'b000 || qb[3*k +: 3] != 3'b000) begin
        lowest = k;
        break;
      end
    end
    for (int k = N - 1; k >= 0; k--) begin
      r = rb[3*k +: 3];
      q = qb[3*k +: 3];
      if (r == 3'b000 && q == 3'b000) continue;
      expR.push_back(r);
      expQ.push_back(q);
      expL.push_back(k == lowest);
      if (r == GAPC || q == GAPC) begin
        expGapN++;
        expScoreA = sat8(expScoreA - PEN_A);
        expScoreB = sat8(expScoreB - PEN_B);
      end else if (r == q) begin
        expMat++;
        expScoreA = sat8(expScoreA + 2);
        expScoreB = sat8(expScoreB + 2);
      end else begin
        expMis++;
        expScoreA = sat8(expScoreA - 1);
        expScoreB = sat8(expScoreB - 1);
      end
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] rb, input logic [W-1:0] qb);
    rBus = rb;
    qBus = qb;
    acc_ready = 1'b1;
    buildModel(rb, qb);
  endtask

  task automatic randomBuses(output logic [W-1:0] rb, output logic [W-1:0] qb, input int padPct);
    rb = '0;
    qb = '0;
    for (int k = 0; k < N; k++) begin
      if ($urandom_range(0, 99) >= padPct) begin
        rb[3*k +: 3] = 3'($urandom_range(0, 7));
        qb[3*k +: 3] = 3'($urandom_range(0, 7));
      end
    end
  endtask

  // readyMode: 0 always ready, 1 toggling, 2 random.
  task automatic collectJob(input int readyMode, input bit holdAcc, input bit pokeAcc,
                            input string name);
    int cyc;
    bit done, stalled, heldL;
    logic [2:0] heldR, heldQ;
    cyc = 0; done = 0; stalled = 0; heldL = 0; heldR = '0; heldQ = '0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        checkOutput({name, ".busyStart"}, aBusy, 1);
        if (!holdAcc) acc_ready = 1'b0;
      end
      if (pokeAcc && cyc == 3) acc_ready = 1'b1;
      if (pokeAcc && cyc == 5) acc_ready = 1'b0;
      if (stalled) begin
        checkOutput({name, ".holdValid"}, aValid, 1);
        checkOutput({name, ".holdR"}, aR, heldR);
        checkOutput({name, ".holdQ"}, aQ, heldQ);
        checkOutput({name, ".holdLast"}, aLast, heldL);
      end
      case (readyMode)
        0: out_ready = 1'b1;
        1: out_ready = cyc[0];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (aValid && out_ready) begin
        if (expR.size() == 0) begin
          checkOutput({name, ".extraBeat"}, 1, 0);
        end else begin
          checkOutput({name, ".beatR"}, aR, expR[0]);
          checkOutput({name, ".beatQ"}, aQ, expQ[0]);
          checkOutput({name, ".beatLast"}, aLast, expL[0]);
          checkOutput({name, ".bValid"}, bValid, 1);
          checkOutput({name, ".bBeatR"}, bR, expR[0]);
          checkOutput({name, ".bBeatQ"}, bQ, expQ[0]);
          checkOutput({name, ".bBeatLast"}, bLast, expL[0]);
          void'(expR.pop_front());
          void'(expQ.pop_front());
          void'(expL.pop_front());
        end
      end
      stalled = aValid && !out_ready;
      heldR = aR;
      heldQ = aQ;
      heldL = aLast;
      if (aRes) begin
        done = 1;
        checkOutput({name, ".missingBeats"}, expR.size(), 0);
        checkOutput({name, ".match"}, aMat, expMat);
        checkOutput({name, ".mismatch"}, aMis, expMis);
        checkOutput({name, ".gap"}, aGap, expGapN);
        checkOutput({name, ".score"}, aScore, expScoreA);
        checkOutput({name, ".bRes"}, bRes, 1);
        checkOutput({name, ".bGap"}, bGap, expGapN);
        checkOutput({name, ".bScore"}, bScore, expScoreB);
        checkOutput({name, ".overrun"}, aOvr, expOvr);
        checkOutput({name, ".bOverrun"}, bOvr, expOvr);
        if (readyMode == 0) checkOutput({name, ".reportCycle"}, cyc, N + 1);
      end
    end
    if (!done) checkOutput({name, ".timeout"}, 0, 1);
    @(negedge clk);
    checkOutput({name, ".resPulse"}, aRes, 0);
    checkOutput({name, ".busyEnd"}, aBusy, 0);
    checkOutput({name, ".scoreHeld"}, aScore, expScoreA);
    checkOutput({name, ".matchHeld"}, aMat, expMat);
    if (holdAcc) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        checkOutput({name, ".noRestart"}, aBusy, 0);
      end
      acc_ready = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [W-1:0] rb, qb;
    rst_n = 1'b0;
    acc_ready = 1'b0;
    out_ready = 1'b0;
    rBus = '0;
    qBus = '0;
    #1;
    checkOutput("rst.valid", aValid, 0);
    checkOutput("rst.busy", aBusy, 0);
    checkOutput("rst.score", aScore, 0);
    checkOutput("rst.overrun", aOvr, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle.busy", aBusy, 0);
    checkOutput("idle.res", aRes, 0);

    // Eight matching slots below two padding slots.
    rb = '0;
    for (int k = 0; k < 8; k++) rb[3*k +: 3] = 3'b001;
    applyStimulus(rb, rb);
    collectJob(0, 0, 0, "match");
    checkOutput("match.score16", aScore, 16);
    checkOutput("match.cnt8", aMat, 8);

    rb = '0; qb = '0;
    rb[8:6] = 3'b001; qb[8:6] = 3'b001;
    rb[5:3] = 3'b010; qb[5:3] = 3'b111;
    rb[2:0] = 3'b011; qb[2:0] = 3'b100;
    applyStimulus(rb, qb);
    collectJob(0, 0, 0, "mixed");
    checkOutput("mixed.scoreNeg1", aScore, -1);

    rb = '0;
    for (int k = 0; k < 8; k++) rb[3*k +: 3] = 3'b001;
    applyStimulus(rb, rb);
    collectJob(1, 0, 0, "backpressure");

    rb = '0; qb = '0;
    for (int k = 0; k < N; k++) begin
      rb[3*k +: 3] = GAPC;
      qb[3*k +: 3] = 3'($urandom_range(1, 7));
    end
    applyStimulus(rb, qb);
    collectJob(0, 0, 0, "saturate");
    checkOutput("saturate.bScoreMin", bScore, -128);
    checkOutput("saturate.bGap10", bGap, 10);

    applyStimulus('0, '0);
    collectJob(0, 0, 0, "allPad");

    randomBuses(rb, qb, 20);
    applyStimulus(rb, qb);
    collectJob(0, 1, 0, "holdHigh");

    rb = '0;
    for (int k = 0; k < 8; k++) rb[3*k +: 3] = 3'b001;
    applyStimulus(rb, rb);
    expOvr = 1'b1;
    collectJob(0, 0, 1, "overrun");
    checkOutput("overrun.noSecondJob", aBusy, 0);

    for (int j = 0; j < 30; j++) begin
      randomBuses(rb, qb, $urandom_range(0, 60));
      applyStimulus(rb, qb);
      collectJob(2, 0, 0, "random");
    end

    // Abort mid-job, then release with acc_ready already high.
    randomBuses(rb, qb, 0);
    applyStimulus(rb, qb);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      acc_ready = 1'b0;
      out_ready = 1'b1;
    end
    #2;
    rst_n = 1'b0;
    acc_ready = 1'b1;
    #1;
    checkOutput("abort.valid", aValid, 0);
    checkOutput("abort.outR", aR, 0);
    checkOutput("abort.outQ", aQ, 0);
    checkOutput("abort.last", aLast, 0);
    checkOutput("abort.res", aRes, 0);
    checkOutput("abort.busy", aBusy, 0);
    checkOutput("abort.overrun", aOvr, 0);
    checkOutput("abort.score", aScore, 0);
    checkOutput("abort.gap", aGap, 0);
    expOvr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("abort.noRes", aRes, 0);
    end
    randomBuses(rb, qb, 30);
    rBus = rb;
    qBus = qb;
    buildModel(rb, qb);
    rst_n = 1'b1;
    collectJob(0, 0, 0, "releaseEdge");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/align_result_collector.md
ALIGN_RESULT_COLLECTOR -- requirements
Module: align_result_collector

Interface
REQ-001 SHALL have parameter L, default 8: subsequence length in bases; slot count N = L+2; aligned bus width 3L+6.
REQ-002 SHALL have parameter GAP, default 3'b111: 3-bit gap code; code 3'b000 is padding.
REQ-003 SHALL have parameter MATCH, default 2: score added per match slot.
REQ-004 SHALL have parameter MISMATCH, default 1: score subtracted per mismatch slot.
REQ-005 SHALL have parameter GAPPEN, default 2: score subtracted per gap slot.
REQ-006 SHALL have port clk input 1: single clock, all state on rising edge.
REQ-007 SHALL have port rst_n input 1: reset; one clock; reset is asynchronous and active-low.
REQ-008 SHALL have port acc_ready input 1: done flag from accelerator, level, may stay high many cycles.
REQ-009 SHALL have port r_aligned_in input 3L+6: aligned R; slot k = bits [3k+2:3k].
REQ-010 SHALL have port q_aligned_in input 3L+6: aligned Q, same slot layout.
REQ-011 SHALL have port out_valid output 1: beat available.
REQ-012 SHALL have port out_ready input 1: consumer accepts beat.
REQ-013 SHALL have port out_r output 3: R code of current beat.
REQ-014 SHALL have port out_q output 3: Q code of current beat.
REQ-015 SHALL have port out_last output 1: final beat of the job.
REQ-016 SHALL have port res_valid output 1: one-cycle pulse, statistics valid.
REQ-017 SHALL have port score output 8: signed alignment score.
REQ-018 SHALL have ports match_cnt, mismatch_cnt, gap_cnt output CW = clog2(N+1) each: slot counts.
REQ-019 SHALL have port busy output 1: job in progress.
REQ-020 SHALL have port overrun output 1: sticky, a new job arrived while busy.

Function
REQ-021 SHALL implement states IDLE, EMIT, REPORT.
REQ-022 IDLE: on the acc_ready rising edge (acc_ready=1, previous sample 0), SHALL capture both buses and the non-padding mask, clear counters and score, and go to EMIT; busy=1 from the next cycle.
REQ-023 A slot SHALL be padding when both codes are 3'b000.
REQ-024 EMIT SHALL scan slot index from N-1 down to 0, one slot per cycle; padding slots are skipped with no beat emitted.
REQ-025 A non-padding slot SHALL drive out_valid=1 with out_r/out_q, holding them stable until out_ready=1.
REQ-026 A beat SHALL be transferred on the cycle where out_valid and out_ready are both 1; the index advances on that cycle.
REQ-027 First out_valid SHALL be no earlier than 1 cycle after the capture cycle; sustained throughput SHALL be 1 beat/cycle when out_ready stays high.
REQ-028 out_last SHALL be 1 only on the beat whose slot is the lowest-index non-padding slot, as taken from the captured mask.
REQ-029 Classification on transfer SHALL be: gap if either code equals GAP; else match if codes are equal; else mismatch.
REQ-030 score SHALL be accumulated signed, saturating at +127 and -128, never wrapping.
REQ-031 After slot 0 is processed, EMIT SHALL go to REPORT; REPORT SHALL pulse res_valid=1 for one cycle, then return to IDLE with busy=0.
REQ-032 score and counts SHALL be held from REPORT until the next capture.
REQ-033 An all-padding capture SHALL emit no beats and reach REPORT after N scan cycles with all statistics zero.
REQ-034 An acc_ready rising edge while busy SHALL be ignored and SHALL set overrun=1; overrun clears only on reset.
REQ-035 acc_ready held high after a job SHALL NOT restart a job; a new job needs a fall and a new rise.

Reset
REQ-036 rst_n=0 SHALL immediately force IDLE with out_valid, out_last, res_valid, busy and overrun at 0, score and all counts at 0, and out_r/out_q at 3'b000.
REQ-037 Reset during EMIT SHALL abort the job with no res_valid pulse.
REQ-038 The edge-detect history SHALL reset to 0, so acc_ready already high at reset release counts as a rising edge.

Verification
REQ-039 Match test: L=8, slots 7..0 have R=Q=3'b001, slots 9..8 padding, out_ready=1 -> 8 consecutive beats, out_last on the 8th, match_cnt=8, score=16.
REQ-040 Mixed test: slots 2..0 are (R,Q) = (001,001), (010,111), (011,100) -> beats in order slot2, slot1, slot0; match=1, gap=1, mismatch=1, score=-1.
REQ-041 Backpressure test: out_ready toggled 0/1 every cycle during the match test -> each beat held stable while stalled, 8 beats total, same statistics.
REQ-042 Saturation test: 10 gap slots with GAPPEN=20 -> score=-128, gap_cnt=10.
REQ-043 Overrun test: acc_ready pulsed again during EMIT -> overrun=1, the running job completes unchanged, no second job starts.
REQ-044 Abort test: rst_n asserted mid-EMIT -> outputs at reset values asynchronously, no res_valid pulse.
